// File: rtl/mac_row_array.sv
// mac_row_array: row of LANES multiply-accumulate lanes with a checksum lane
//   clk, rst_n          : clock, synchronous active-low reset
//   start               : pulse in IDLE begins a new row
//   a_valid/a_ready     : beat handshake; a_data scalar, b_data lane-packed row
//   mux_sel             : beats accepted so far, holds at DEPTH-1 after the last
//   c_data/c_valid/c_ready : accumulated row and its handshake
//   busy                : not IDLE
//   chk_err             : lane sum 0..LANES-2 differs from lane LANES-1
module mac_row_array #(
    parameter int LANES  = 33,
    parameter int DW     = 32,
    parameter int DEPTH  = 32,
    parameter int CHK_EN = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       a_valid,
    output logic                       a_ready,
    input  logic [DW-1:0]              a_data,
    input  logic [LANES*DW-1:0]        b_data,
    output logic [$clog2(DEPTH)-1:0]   mux_sel,
    output logic [LANES*DW-1:0]        c_data,
    output logic                       c_valid,
    input  logic                       c_ready,
    output logic                       busy,
    output logic                       chk_err
);
    localparam int SW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;
    state_t                   state_q, state_d;
    logic [SW-1:0]            mux_sel_q, mux_sel_d;
    logic [1:0]               drain_q, drain_d;
    logic [DW-1:0]            a_q, a_d;
    logic [LANES-1:0][DW-1:0] b_q, b_d, p_q, p_d, acc_q, acc_d;
    logic                     v1_q, v1_d, v2_q, v2_d;
    logic                     chk_err_q, chk_err_d;
    logic [DW-1:0]            sum;
    logic                     accept;
    always_comb begin
        accept    = a_valid && state_q == ACC;
        state_d   = state_q;
        mux_sel_d = mux_sel_q;
        drain_d   = drain_q;
        chk_err_d = chk_err_q;
        a_d       = accept ? a_data : a_q;
        b_d       = accept ? b_data : b_q;
        v1_d      = accept;
        v2_d      = v1_q;
        sum       = '0;
        for (int k = 0; k < LANES; k++) begin
            p_d[k]   = a_q * b_q[k];
            // bubbles (v2_q low) leave the accumulators untouched
            acc_d[k] = v2_q ? acc_q[k] + p_q[k] : acc_q[k];
        end
        for (int k = 0; k < LANES - 1; k++) sum = sum + acc_q[k];
        case (state_q)
            IDLE: if (start) begin
                state_d   = ACC;
                acc_d     = '0;
                mux_sel_d = '0;
                chk_err_d = 1'b0;
            end
            ACC: if (accept) begin
                state_d   = mux_sel_q == SW'(DEPTH - 1) ? DRAIN : ACC;
                mux_sel_d = mux_sel_q == SW'(DEPTH - 1) ? mux_sel_q : mux_sel_q + SW'(1);
                drain_d   = 2'd0;
            end
            // two edges flush product and accumulate stages; the third registers the checksum
            DRAIN: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == 2'd2) begin
                    state_d   = DONE;
                    chk_err_d = (CHK_EN != 0) && (sum != acc_q[LANES-1]);
                end
            end
            default: if (c_ready) state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mux_sel_q <= '0;
            drain_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            p_q       <= '0;
            acc_q     <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            chk_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mux_sel_q <= mux_sel_d;
            drain_q   <= drain_d;
            a_q       <= a_d;
            b_q       <= b_d;
            p_q       <= p_d;
            acc_q     <= acc_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            chk_err_q <= chk_err_d;
        end
    end
    assign a_ready = state_q == ACC;
    assign c_valid = state_q == DONE;
    assign busy    = state_q != IDLE;
    assign mux_sel = mux_sel_q;
    assign c_data  = acc_q;
    assign chk_err = chk_err_q;
endmodule

// File: tb/tb_mac_row_array.sv
// tb_mac_row_array: directed rows against a beat-level row model
module tb_mac_row_array;
    localparam int L = 4, W = 8, D = 4;
    logic clk = 0, rst_n = 0, start = 0, a_valid = 0, c_ready = 0;
    logic a_ready, c_valid, busy, chk_err;
    logic [W-1:0] a_data = '0;
    logic [L*W-1:0] b_data = '0, c_data;
    logic [1:0] mux_sel;
    int n_chk = 0, n_fail = 0;
    int cyc = 0, last_edge = 0, beats = 0;
    bit in_row = 0, echk = 0;
    logic [W-1:0] er [L] = '{default: '0};
    mac_row_array #(.LANES(L), .DW(W), .DEPTH(D), .CHK_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_valid(a_valid), .a_ready(a_ready),
        .a_data(a_data), .b_data(b_data), .mux_sel(mux_sel), .c_data(c_data),
        .c_valid(c_valid), .c_ready(c_ready), .busy(busy), .chk_err(chk_err)
    );
    always #5 clk = ~clk;
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    function automatic logic [31:0] model_row();
        logic [31:0] r;
        for (int k = 0; k < L; k++) r[k*W +: W] = er[k];
        return r;
    endfunction
    // Row model: the row is the mod-256 sum of a*b over accepted beats;
    // c_valid is due 3 edges after the DEPTH-th acceptance and lasts until consumed.
    always @(negedge clk) begin : model
        logic exp_cv;
        logic [W-1:0] s;
        cyc++;
        exp_cv = in_row && beats == D && cyc >= last_edge + 3;
        check("m_c_valid", c_valid, exp_cv);
        check("m_busy", busy, in_row);
        check("m_a_ready", a_ready, in_row && beats < D);
        check("m_mux_sel", mux_sel, beats == D ? D - 1 : beats);
        if (exp_cv || !in_row) begin
            check("m_c_data", c_data, model_row());
            check("m_chk_err", chk_err, echk);
        end
        if (!rst_n) begin
            in_row = 0; beats = 0; echk = 0; er = '{default: '0};
        end else if (!in_row && start) begin
            in_row = 1; beats = 0; echk = 0; er = '{default: '0};
        end else if (in_row && beats < D && a_valid) begin
            for (int k = 0; k < L; k++) er[k] = er[k] + W'(a_data * b_data[k*W +: W]);
            beats++;
            if (beats == D) begin
                last_edge = cyc + 1;
                s = er[0] + er[1] + er[2];
                echk = s != er[3];
            end
        end else if (exp_cv && c_ready) in_row = 0;
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic run_row(input logic [7:0] av [4], input logic [31:0] bv [4], input int gp [4], input bit noisy);
        start = 1; tick(); start = 0;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gp[i]; g++) begin
                a_valid = 0; a_data = W'($urandom); b_data = $urandom;
                start = noisy; tick(); start = 0;
            end
            a_valid = 1; a_data = av[i]; b_data = bv[i]; tick();
        end
        a_valid = 0; a_data = W'($urandom); b_data = $urandom;
    endtask
    task automatic wait_done(input string nm);
        int n = 0;
        while (!c_valid && n < 20) begin tick(); n++; end
        check(nm, n, 3);
    endtask
    task automatic consume(input logic [31:0] exp);
        c_ready = 1; tick(); c_ready = 0;
        check("idle_after_ready", busy, 0);
        check("c_data_retained", c_data, exp);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        logic [7:0]  a14 [4] = '{1, 2, 3, 4};
        logic [7:0]  aff [4] = '{255, 255, 255, 255};
        logic [31:0] b1  [4] = '{32'h06030201, 32'h06030201, 32'h06030201, 32'h06030201};
        logic [31:0] b2  [4] = '{32'h06030201, 32'h07030201, 32'h06030201, 32'h06030201};
        logic [31:0] bff [4] = '{32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff};
        int g0 [4] = '{0, 0, 0, 0};
        int gg [4] = '{2, 0, 3, 1};
        repeat (3) tick();
        check("rst_a_ready", a_ready, 0);
        check("rst_c_valid", c_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_mux_sel", mux_sel, 0);
        check("rst_c_data", c_data, 0);
        check("rst_chk_err", chk_err, 0);
        rst_n = 1; tick();
        run_row(a14, b1, g0, 0);
        wait_done("row1_latency");
        check("row1_c_data", c_data, 32'h3c1e140a);
        check("row1_chk_err", chk_err, 0);
        check("row1_mux_sel", mux_sel, 3);
        check("row1_model", model_row(), 32'h3c1e140a);
        consume(32'h3c1e140a);
        run_row(a14, b2, g0, 0);
        wait_done("row2_latency");
        check("row2_c_data", c_data, 32'h3e1e140a);
        check("row2_chk_err", chk_err, 1);
        consume(32'h3e1e140a);
        run_row(aff, bff, g0, 0);
        wait_done("row3_latency");
        check("row3_c_data", c_data, 32'h04040404);
        check("row3_chk_err", chk_err, 1);
        check("row3_model", model_row(), 32'h04040404);
        consume(32'h04040404);
        run_row(a14, b1, gg, 1);
        wait_done("row4_latency");
        start = 1; tick(); start = 0;
        for (int i = 0; i < 10; i++) begin
            check("hold_c_data", c_data, 32'h3c1e140a);
            check("hold_c_valid", c_valid, 1);
            tick();
        end
        c_ready = 1; start = 1; tick(); c_ready = 0; start = 0;
        check("ready_start_idle", busy, 0);
        tick();
        check("start_ignored", busy, 0);
        start = 1; tick(); start = 0;
        a_valid = 1; a_data = 1; b_data = b1[0]; tick();
        a_data = 2; tick();
        a_valid = 0; rst_n = 0; tick();
        check("midrst_busy", busy, 0);
        check("midrst_a_ready", a_ready, 0);
        check("midrst_mux_sel", mux_sel, 0);
        check("midrst_c_data", c_data, 0);
        check("midrst_c_valid", c_valid, 0);
        rst_n = 1; repeat (6) tick();
        check("midrst_no_cvalid", c_valid, 0);
        run_row(a14, b1, g0, 0);
        wait_done("row5_latency");
        check("row5_c_data", c_data, 32'h3c1e140a);
        check("row5_chk_err", chk_err, 0);
        consume(32'h3c1e140a);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mac_row_array.md
MAC_ROW_ARRAY -- requirements
Module: mac_row_array

Interface
REQ-001 Parameter LANES, default 33, number of parallel MAC lanes; lane LANES-1 is the checksum lane when CHK_EN=1.
REQ-002 Parameter DW, default 32, operand and accumulator width in bits.
REQ-003 Parameter DEPTH, default 32, number of A/B beats accumulated per output row; DEPTH >= 2.
REQ-004 Parameter CHK_EN, default 1, enables the row-checksum comparison.
REQ-005 Port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1, synchronous, active-low reset.
REQ-007 Port start, input, 1, a single-cycle pulse that begins a new row.
REQ-008 Port a_valid, input, 1, A scalar and B row are presented.
REQ-009 Port a_ready, output, 1, the block accepts a beat.
REQ-010 Port a_data, input, DW, the A element for the current beat.
REQ-011 Port b_data, input, LANES*DW, the B row; lane k occupies bits [k*DW +: DW].
REQ-012 Port mux_sel, output, clog2(DEPTH), the index of the next A element to fetch, equal to the count of beats accepted.
REQ-013 Port c_data, output, LANES*DW, the accumulated C row, lane-packed as b_data.
REQ-014 Port c_valid, output, 1, c_data is final.
REQ-015 Port c_ready, input, 1, the consumer takes the row.
REQ-016 Port busy, output, 1, high in every state except IDLE.
REQ-017 Port chk_err, output, 1, a checksum mismatch occurred; valid while c_valid=1.

Function
REQ-018 The FSM SHALL use the states IDLE, ACC, DRAIN and DONE.
REQ-019 In IDLE, start=1 SHALL clear all accumulators, the beat counter, mux_sel and chk_err, then enter ACC; in any other state, start SHALL be ignored.
REQ-020 a_ready SHALL equal (state==ACC); a beat is accepted on an edge where a_valid & a_ready.
REQ-021 Pipeline: the edge that accepts a beat registers a_data/b_data; the next edge registers the lane products; the following edge adds each product into its lane accumulator.
REQ-022 Products and sums SHALL be truncated to the low DW bits, unsigned, with modulo 2^DW wrap and no saturation.
REQ-023 Gaps in a_valid SHALL insert pipeline bubbles that add nothing; the result SHALL be independent of gap pattern.
REQ-024 mux_sel SHALL increment on each accepted beat and hold at DEPTH-1 after the last beat; it SHALL never wrap within a row.
REQ-025 The DEPTH-th accepted beat SHALL move the FSM ACC->DRAIN; no further beats are accepted.
REQ-026 DRAIN SHALL last until the last product is accumulated, then the checksum result is registered and the FSM enters DONE.
REQ-027 c_valid SHALL be asserted exactly 3 cycles after the edge accepting the last beat and SHALL equal (state==DONE).
REQ-028 When CHK_EN=1, chk_err SHALL be set if the mod-2^DW sum of lanes 0..LANES-2 differs from lane LANES-1; when CHK_EN=0, chk_err SHALL be 0.
REQ-029 c_data and chk_err SHALL hold stable in DONE until c_ready=1.
REQ-030 In DONE, c_ready=1 SHALL return the FSM to IDLE on that edge; start asserted in the same cycle is ignored.
REQ-031 c_data SHALL retain the last row after leaving DONE until the next start.

Reset
REQ-032 rst_n=0 at an edge SHALL force IDLE, a_ready=0, c_valid=0, busy=0, chk_err=0, mux_sel=0, c_data=0 and the pipeline registers to 0, overriding every other input.
REQ-033 Reset asserted mid-row (ACC/DRAIN/DONE) SHALL discard the partial row with no c_valid pulse.

Verification
REQ-034 LANES=4, DW=8, DEPTH=4, b_data lanes {1,2,3,6}, a_data=1..4 back-to-back -> c_data lanes {10,20,30,60}, chk_err=0, c_valid 3 cycles after the 4th beat.
REQ-035 Same stimulus with lane 3 of beat 2 forced to 7 -> lane 3 = 62, chk_err=1.
REQ-036 DW=8, a_data=255 and b lanes=255 for 4 beats -> each lane = (4*65025) mod 256 = 4, no error flag beyond the checksum rule.
REQ-037 Random a_valid gaps, plus start pulses during ACC and DONE -> identical c_data to the gap-free run, with the start pulses ignored.
REQ-038 c_ready held low 10 cycles in DONE -> c_data and c_valid stable; c_ready=1 -> IDLE on the next edge.
REQ-039 rst_n=0 after beat 2 -> all outputs reach their reset values on the next edge; a new row then yields the correct result.
